// File: rtl/fp_div_seq.sv
// fp_div_seq: initiator for an iterative FP divide unit (start/done).
// Accepts requests on a valid/ready channel and pulses unit_start_o.
// It holds the operands stable while the unit works and waits for done.
// The result, flags and tag are returned on a valid/ready response
// channel. A watchdog answers with a qNaN/NV response if done never comes.
// Ports:
//   clk_i, reset_i                 clock, async active-high reset
//   req_valid_i/ready_o, req_*     request channel (a, b, rnd, tag)
//   unit_start_o, unit_a/b/rnd_o   launch pulse and operands to unit
//   unit_done_i, unit_result/flags done pulse and payload from unit
//   rsp_valid_o/ready_i, rsp_*     response (result, flags, tag, timeout)
//   busy_o                         an operation is in flight
// Optional: define FP_DIV_SEQ_PREFETCH_EN to add a one-entry request
// buffer that is filled while an operation is in progress.

package fp_div_seq_pkg;
   typedef enum logic [1:0] {FP32, FP64, FP16, BF16} fp_format_e;

   function automatic int unsigned fp_width(fp_format_e f);
      unique case (f)
         FP64:       return 64;
         FP16, BF16: return 16;
         default:    return 32;
      endcase
   endfunction

   function automatic logic [63:0] fp_qnan(fp_format_e f);
      unique case (f)
         FP64:    return 64'h7FF8_0000_0000_0000;
         FP16:    return 64'h7E00;
         BF16:    return 64'h7FC0;
         default: return 64'h7FC0_0000;
      endcase
   endfunction
endpackage

module fp_div_seq
   import fp_div_seq_pkg::*;
#(
   parameter fp_format_e  FP_FORMAT   = FP32,
   parameter int unsigned TAG_W       = 4,
   parameter int unsigned TIMEOUT_CYC = 64,
   localparam int unsigned FP_WIDTH   = fp_width(FP_FORMAT)
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [FP_WIDTH-1:0] req_a_i,
   input  logic [FP_WIDTH-1:0] req_b_i,
   input  logic [2:0]          req_rnd_i,
   input  logic [TAG_W-1:0]    req_tag_i,
   output logic                unit_start_o,
   output logic [FP_WIDTH-1:0] unit_a_o,
   output logic [FP_WIDTH-1:0] unit_b_o,
   output logic [2:0]          unit_rnd_o,
   input  logic                unit_done_i,
   input  logic [FP_WIDTH-1:0] unit_result_i,
   input  logic [4:0]          unit_flags_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [FP_WIDTH-1:0] rsp_result_o,
   output logic [4:0]          rsp_flags_o,
   output logic [TAG_W-1:0]    rsp_tag_o,
   output logic                rsp_timeout_o,
   output logic                busy_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [FP_WIDTH-1:0] QNAN = FP_WIDTH'(fp_qnan(FP_FORMAT));
   localparam logic [4:0] NV_FLAG = 5'b10000;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_e;

   state_e state, next_state;

   logic [FP_WIDTH-1:0] op_a, op_b;
   logic [2:0]          op_rnd;
   logic [TAG_W-1:0]    op_tag;
   logic [CNT_W-1:0]    cnt;
   logic [FP_WIDTH-1:0] res;
   logic [4:0]          flags;
   logic                timeout;
   logic                expire;

`ifdef FP_DIV_SEQ_PREFETCH_EN
   logic                buf_full;
   logic [FP_WIDTH-1:0] buf_a, buf_b;
   logic [2:0]          buf_rnd;
   logic [TAG_W-1:0]    buf_tag;
`endif

   assign expire        = (cnt == CNT_MAX);
   assign busy_o        = (state != IDLE);
   assign unit_a_o      = op_a;
   assign unit_b_o      = op_b;
   assign unit_rnd_o    = op_rnd;
   assign rsp_result_o  = res;
   assign rsp_flags_o   = flags;
   assign rsp_tag_o     = op_tag;
   assign rsp_timeout_o = timeout;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state   = state;
      req_ready_o  = 1'b0;
      unit_start_o = 1'b0;
      rsp_valid_o  = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) next_state = LAUNCH;
         end
         LAUNCH: begin
            unit_start_o = 1'b1;
            next_state   = WAIT;
         end
         WAIT: begin
            if (unit_done_i || expire) next_state = HOLD;
         end
         HOLD: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               next_state = IDLE;
`ifdef FP_DIV_SEQ_PREFETCH_EN
               // Pending work launches directly without passing IDLE.
               if (buf_full || req_valid_i) next_state = LAUNCH;
`endif
            end
         end
         default: next_state = IDLE;
      endcase
`ifdef FP_DIV_SEQ_PREFETCH_EN
      if (state != IDLE) req_ready_o = !buf_full;
`endif
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         op_a    <= '0;
         op_b    <= '0;
         op_rnd  <= '0;
         op_tag  <= '0;
         cnt     <= '0;
         res     <= '0;
         flags   <= '0;
         timeout <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid_i) begin
                  op_a   <= req_a_i;
                  op_b   <= req_b_i;
                  op_rnd <= req_rnd_i;
                  op_tag <= req_tag_i;
               end
            end
            LAUNCH: cnt <= '0;
            WAIT: begin
               // Saturate so the counter can never wrap.
               if (!expire) cnt <= cnt + CNT_W'(1);
               // done has priority over a coincident expiry.
               if (unit_done_i) begin
                  res     <= unit_result_i;
                  flags   <= unit_flags_i;
                  timeout <= 1'b0;
               end else if (expire) begin
                  res     <= QNAN;
                  flags   <= NV_FLAG;
                  timeout <= 1'b1;
               end
            end
            HOLD: begin
`ifdef FP_DIV_SEQ_PREFETCH_EN
               if (rsp_ready_i) begin
                  if (buf_full) begin
                     op_a   <= buf_a;
                     op_b   <= buf_b;
                     op_rnd <= buf_rnd;
                     op_tag <= buf_tag;
                  end else if (req_valid_i) begin
                     op_a   <= req_a_i;
                     op_b   <= req_b_i;
                     op_rnd <= req_rnd_i;
                     op_tag <= req_tag_i;
                  end
               end
`endif
            end
            default: ;
         endcase
      end
   end

`ifdef FP_DIV_SEQ_PREFETCH_EN
   // A request taken on the response handshake goes straight to the
   // capture registers, so the buffer only fills when no launch follows.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         buf_full <= 1'b0;
         buf_a    <= '0;
         buf_b    <= '0;
         buf_rnd  <= '0;
         buf_tag  <= '0;
      end else if (state == HOLD && rsp_ready_i) begin
         buf_full <= 1'b0;
      end else if (state != IDLE && req_valid_i && !buf_full) begin
         buf_full <= 1'b1;
         buf_a    <= req_a_i;
         buf_b    <= req_b_i;
         buf_rnd  <= req_rnd_i;
         buf_tag  <= req_tag_i;
      end
   end
`endif

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: scoreboard bench for fp_div_seq with a stub unit.
// Stimulus pushes expected responses; a monitor pops and compares.

module tb_fp_div_seq;
   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_a_i, req_b_i;
   logic [2:0]  req_rnd_i;
   logic [3:0]  req_tag_i;
   logic        unit_start_o;
   logic [31:0] unit_a_o, unit_b_o;
   logic [2:0]  unit_rnd_o;
   logic        unit_done_i = 1'b0;
   logic [31:0] unit_result_i = '0;
   logic [4:0]  unit_flags_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b1;
   logic [31:0] rsp_result_o;
   logic [4:0]  rsp_flags_o;
   logic [3:0]  rsp_tag_o;
   logic        rsp_timeout_o;
   logic        busy_o;

   fp_div_seq #(.TAG_W(4), .TIMEOUT_CYC(TO)) dut (
      .clk_i(clk), .reset_i(reset_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_a_i(req_a_i), .req_b_i(req_b_i),
      .req_rnd_i(req_rnd_i), .req_tag_i(req_tag_i),
      .unit_start_o(unit_start_o), .unit_a_o(unit_a_o),
      .unit_b_o(unit_b_o), .unit_rnd_o(unit_rnd_o),
      .unit_done_i(unit_done_i), .unit_result_i(unit_result_i),
      .unit_flags_i(unit_flags_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_flags_o(rsp_flags_o),
      .rsp_tag_o(rsp_tag_o), .rsp_timeout_o(rsp_timeout_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  flg;
      logic [3:0]  tag;
      logic        to;
      int          lat;
      int          acc;
   } exp_t;

   typedef struct {
      int          n;
      logic [31:0] a, b, res;
      logic [2:0]  rnd;
      logic [4:0]  flg;
   } stub_t;

   exp_t  sbq[$];
   stub_t stq[$];
   int checks = 0;
   int failures = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Stub iterative unit: done N cycles after start with a chosen payload;
   // random spurious done pulses whenever it is not busy.
   stub_t cur;
   bit    act = 0;
   bit    spur_en = 0;
   int    st_cyc = 0;
   logic  prev_start = 1'b0;

   always @(negedge clk) begin
      if (!reset_i && unit_start_o) begin
         chk("start_one_cycle", prev_start, 0);
         if (stq.size() == 0) begin
            chk("start_unexpected", 1, 0);
         end else begin
            cur = stq.pop_front();
            act = 1;
            st_cyc = cyc;
            chk("unit_a", unit_a_o, cur.a);
            chk("unit_b", unit_b_o, cur.b);
            chk("unit_rnd", unit_rnd_o, cur.rnd);
         end
      end
      prev_start = unit_start_o;
   end

   always @(posedge clk) begin
      #1;
      if (act && cyc == st_cyc + cur.n) begin
         unit_done_i   = 1'b1;
         unit_result_i = cur.res;
         unit_flags_i  = cur.flg;
         act = 0;
      end else begin
         unit_done_i   = !act && spur_en && ($urandom_range(0, 3) == 0);
         unit_result_i = $urandom;
         unit_flags_i  = 5'($urandom);
      end
   end

   int rdy_mode = 1;
   always @(posedge clk) begin
      #1;
      rsp_ready_i = (rdy_mode == 1) ||
                    (rdy_mode == 2 && $urandom_range(0, 2) != 0);
   end

   // Monitor
   bit   seen = 0;
   bit   hs_prev = 0;
   exp_t e;

   always @(negedge clk) begin
      if (reset_i) begin
         seen = 0;
         hs_prev = 0;
      end else begin
         if (hs_prev) begin
            chk("valid_drop", rsp_valid_o, 0);
`ifndef FP_DIV_SEQ_PREFETCH_EN
            chk("idle_after_hs", busy_o, 0);
`endif
         end
         if (rsp_valid_o) begin
            if (!seen) begin
               if (sbq.size() == 0) begin
                  chk("rsp_unexpected", 1, 0);
               end else begin
                  e = sbq.pop_front();
                  seen = 1;
                  chk("rsp_result", rsp_result_o, e.res);
                  chk("rsp_flags", rsp_flags_o, e.flg);
                  chk("rsp_tag", rsp_tag_o, e.tag);
                  chk("rsp_timeout", rsp_timeout_o, e.to);
                  if (e.lat >= 0) chk("rsp_latency", cyc - e.acc, e.lat);
               end
            end else begin
               chk("rsp_stable",
                   {rsp_result_o, rsp_flags_o, rsp_tag_o, rsp_timeout_o},
                   {e.res, e.flg, e.tag, e.to});
            end
`ifndef FP_DIV_SEQ_PREFETCH_EN
            chk("req_ready_in_hold", req_ready_o, 0);
`endif
            if (rsp_ready_i) seen = 0;
         end
         hs_prev = rsp_valid_o && rsp_ready_i;
      end
   end

   task automatic issue(logic [31:0] a, logic [31:0] b, logic [2:0] rnd,
                        logic [3:0] tag, int n, logic [31:0] res,
                        logic [4:0] flg);
      exp_t  x;
      stub_t s;
      int    k = 0;
      if (n >= 1 && n <= TO) begin
         x.res = res; x.flg = flg; x.to = 1'b0; x.lat = n + 2;
      end else begin
         x.res = 32'h7FC0_0000; x.flg = 5'b10000;
         x.to = 1'b1; x.lat = TO + 2;
      end
`ifdef FP_DIV_SEQ_PREFETCH_EN
      x.lat = -1;
`endif
      x.tag = tag;
      s.n = n; s.a = a; s.b = b; s.rnd = rnd; s.res = res; s.flg = flg;
      req_valid_i = 1'b1;
      req_a_i = a; req_b_i = b; req_rnd_i = rnd; req_tag_i = tag;
      @(negedge clk);
      while (!req_ready_o && k < 2000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 2000) chk("req_accept_timeout", 1, 0);
      x.acc = cyc;
      sbq.push_back(x);
      stq.push_back(s);
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((sbq.size() != 0 || seen || busy_o) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 3000) chk("idle_timeout", 1, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset_i = 1'b1;
      req_valid_i = 1'b0;
      req_a_i = '0; req_b_i = '0; req_rnd_i = '0; req_tag_i = '0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_req_ready", req_ready_o, 1);
         chk("rst_outs",
             {unit_start_o, rsp_valid_o, busy_o, rsp_timeout_o,
              unit_a_o, rsp_result_o},
             0);
      end
      @(posedge clk);
      #1;
      reset_i = 1'b0;

      // Basic divide 1.0 / 2.0
      issue(32'h3F80_0000, 32'h4000_0000, 3'd0, 4'd3, 10,
            32'h3F00_0000, 5'd0);
      wait_idle();

      // Response backpressure
      rdy_mode = 0;
      issue(32'h4040_0000, 32'h3F80_0000, 3'd1, 4'd5, 6,
            32'h4040_0000, 5'b00001);
      begin
         int k = 0;
         while (!seen && k < 200) begin
            @(negedge clk);
            k++;
         end
         if (k >= 200) chk("bp_rsp_timeout", 1, 0);
      end
      repeat (5) @(negedge clk);
      rdy_mode = 1;
      wait_idle();

      // Watchdog, done exactly on expiry, just past expiry, minimal N
      issue(32'h4120_0000, 32'h0, 3'd2, 4'd9, 100000, 32'h1234_5678, 5'd2);
      wait_idle();
      issue(32'h4110_0000, 32'h4040_0000, 3'd0, 4'd10, TO,
            32'h4040_0000, 5'd0);
      wait_idle();
      issue(32'h4110_0000, 32'h4040_0000, 3'd0, 4'd11, TO + 1,
            32'h4040_0000, 5'd0);
      wait_idle();
      issue(32'h4000_0000, 32'h4000_0000, 3'd4, 4'd12, 1,
            32'h3F80_0000, 5'd0);
      wait_idle();

      // Reset four cycles after start; the stub's late done must be ignored
      issue(32'h4080_0000, 32'h4000_0000, 3'd0, 4'd7, 10,
            32'h4000_0000, 5'd0);
      repeat (4) @(posedge clk);
      #1;
      reset_i = 1'b1;
      sbq.delete();
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      repeat (12) begin
         @(negedge clk);
         chk("rst_mid_no_rsp", {rsp_valid_o, busy_o, req_ready_o}, 3'b001);
      end
      chk("rst_mid_outs",
          {rsp_result_o, rsp_flags_o, rsp_tag_o, rsp_timeout_o, unit_a_o},
          0);
      @(posedge clk);
      #1;

      // Randomized phase with backpressure and spurious done pulses
      spur_en = 1;
      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         int unsigned r;
         int n;
         r = $urandom_range(0, 9);
         if (r < 7)      n = $urandom_range(1, 20);
         else if (r < 9) n = $urandom_range(60, 64);
         else            n = $urandom_range(65, 75);
         issue($urandom, $urandom, 3'($urandom_range(0, 4)),
               4'($urandom), n, $urandom, 5'($urandom));
         if (i % 4 == 0) wait_idle();
      end
      wait_idle();
      chk("sb_drained", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
